// File: rtl/keypad_matrix_scanner_if.sv
// Keypad matrix scanner interface: board matrix pins plus the debounced
// key levels, strobe and code delivered to the game top.
// master: the scanner (drives columns and key outputs, reads rows).
// slave:  the board/consumer side (drives rows, reads everything else).
interface keypad_matrix_scanner_if;
  logic [3:0] KEY_ROW;
  logic [2:0] KEY_COL;
  logic [9:0] Keypad;
  logic       KeypadHash;
  logic       KeypadStar;
  logic       key_strobe;
  logic [3:0] key_code;
  logic       key_multi;

  modport master (
    input  KEY_ROW,
    output KEY_COL, Keypad, KeypadHash, KeypadStar, key_strobe, key_code, key_multi
  );

  modport slave (
    output KEY_ROW,
    input  KEY_COL, Keypad, KeypadHash, KeypadStar, key_strobe, key_code, key_multi
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad matrix scanner with whole-matrix debounce.
// Drives one column at a time for SCAN_DIV cycles, samples the synchronised
// rows into a 12-bit snapshot (bit r*3+c), and commits a snapshot only after
// DEBOUNCE_CNT identical full scans. A press from an idle keypad produces a
// one-cycle key_strobe and loads key_code with the lowest-code key.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (re-strobe every REPEAT_SCANS
// full scans while a non-zero committed state is held).
module keypad_matrix_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 40
) (
  input  logic                    CLK,
  input  logic                    RST,
  keypad_matrix_scanner_if.master kp
);

  localparam int               DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE_CNT);

  // Parameter range checks at elaboration time.
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 4");
  end
  if ((DEBOUNCE_CNT < 1) || (DEBOUNCE_CNT > 15)) begin : g_bad_debounce
    $error("DEBOUNCE_CNT must be in 1..15");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("REPEAT_SCANS must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COL0 = 2'd1,
    S_COL1 = 2'd2,
    S_COL2 = 2'd3
  } state_t;

  // Lowest-code key present; priority 0,1..9,'*','#'. Snapshot index r*3+c.
  function automatic logic [3:0] lowest_code(input logic [11:0] m);
    logic [3:0] code;
    if      (m[10]) code = 4'd0;
    else if (m[0])  code = 4'd1;
    else if (m[1])  code = 4'd2;
    else if (m[2])  code = 4'd3;
    else if (m[3])  code = 4'd4;
    else if (m[4])  code = 4'd5;
    else if (m[5])  code = 4'd6;
    else if (m[6])  code = 4'd7;
    else if (m[7])  code = 4'd8;
    else if (m[8])  code = 4'd9;
    else if (m[9])  code = 4'd10;
    else if (m[11]) code = 4'd11;
    else            code = 4'd0;
    return code;
  endfunction

  // True when two or more bits are set (clearing the lowest set bit leaves some).
  function automatic logic many_keys(input logic [11:0] m);
    return (m & (m - 12'd1)) != 12'd0;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       key_col_q, key_col_d;
  logic [1:0]       col_s;
  logic             sample_s;
  logic [11:0]      snap_q, snap_d;
  logic             snap_done_q, snap_done_d;
  logic [11:0]      prev_q, prev_d;
  logic [3:0]       stable_q, stable_d;
  logic             pend_q, pend_d;
  logic [11:0]      committed_q, committed_d;
  logic             strobe_q, strobe_d;
  logic [3:0]       code_q, code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta_q <= 4'b0000;
      row_sync_q <= 4'b0000;
    end else begin
      row_meta_q <= kp.KEY_ROW;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan FSM state, column divider and registered column drive.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      key_col_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      key_col_q <= key_col_d;
    end
  end

  // Scan FSM next state: each column held SCAN_DIV cycles, sample on the last.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sample_s = 1'b0;
    col_s    = 2'd0;
    case (state_q)
      S_IDLE: begin
        state_d = S_COL0;
        div_d   = '0;
      end
      S_COL0, S_COL1, S_COL2: begin
        if (state_q == S_COL0) begin
          col_s = 2'd0;
        end else if (state_q == S_COL1) begin
          col_s = 2'd1;
        end else begin
          col_s = 2'd2;
        end
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          sample_s = 1'b1;
          if (state_q == S_COL0) begin
            state_d = S_COL1;
          end else if (state_q == S_COL1) begin
            state_d = S_COL2;
          end else begin
            state_d = S_COL0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase
    case (state_d)
      S_COL0:  key_col_d = 3'b001;
      S_COL1:  key_col_d = 3'b010;
      S_COL2:  key_col_d = 3'b100;
      default: key_col_d = 3'b000;
    endcase
  end

  // Snapshot, debounce, commit and strobe state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snap_q      <= 12'd0;
      snap_done_q <= 1'b0;
      prev_q      <= 12'd0;
      stable_q    <= 4'd0;
      pend_q      <= 1'b0;
      committed_q <= 12'd0;
      strobe_q    <= 1'b0;
      code_q      <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      snap_q      <= snap_d;
      snap_done_q <= snap_done_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      pend_q      <= pend_d;
      committed_q <= committed_d;
      strobe_q    <= strobe_d;
      code_q      <= code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // Snapshot capture, whole-matrix debounce, commit and press strobe.
  always_comb begin
    snap_d      = snap_q;
    snap_done_d = sample_s && (state_q == S_COL2);
    prev_d      = prev_q;
    stable_d    = stable_q;
    pend_d      = 1'b0;
    committed_d = committed_q;
    strobe_d    = 1'b0;
    code_d      = code_q;

    if (sample_s) begin
      for (int r = 0; r < 4; r++) begin
        snap_d[r*3 + int'(col_s)] = row_sync_q[r];
      end
    end else begin
      snap_d = snap_q;
    end

    // A commit is only scheduled when the stable value differs from the
    // committed one, so a held key does not re-commit every scan.
    if (snap_done_q) begin
      if (snap_q == prev_q) begin
        if (stable_q >= STABLE_MAX) begin
          stable_d = STABLE_MAX;
        end else begin
          stable_d = stable_q + 4'd1;
        end
      end else begin
        stable_d = 4'd1;
        prev_d   = snap_q;
      end
      pend_d = (stable_d == STABLE_MAX) && (snap_q != committed_q);
    end else begin
      pend_d = 1'b0;
    end

    if (pend_q) begin
      committed_d = prev_q;
      if ((committed_q == 12'd0) && (prev_q != 12'd0)) begin
        strobe_d = 1'b1;
        code_d   = lowest_code(prev_q);
      end else begin
        strobe_d = 1'b0;
      end
    end else begin
      committed_d = committed_q;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d = rep_q;
    if (pend_q) begin
      rep_d = '0;
    end else if (snap_done_q && (committed_q != 12'd0)) begin
      if (rep_q == REP_LAST) begin
        rep_d    = '0;
        strobe_d = 1'b1;
        code_d   = lowest_code(committed_q);
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end else begin
      rep_d = rep_q;
    end
`endif
  end

  assign kp.KEY_COL    = key_col_q;
  assign kp.key_strobe = strobe_q;
  assign kp.key_code   = code_q;
  assign kp.Keypad     = {committed_q[8:0], committed_q[10]};
  assign kp.KeypadStar = committed_q[9];
  assign kp.KeypadHash = committed_q[11];
  assign kp.key_multi  = many_keys(committed_q);

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives the 4x3 phone-style key matrix and produces the debounced key levels that the game top consumes: Keypad[9:0] (digit n on bit n) and KeypadHash.
- Sits between the board matrix pins and the top-level keypad inputs, replacing direct switch wiring.
- Scans one column at a time, samples the rows, debounces whole-matrix snapshots and emits a one-cycle press strobe plus an encoded key code.

Parameters:
SCAN_DIV, 50000, clock cycles each column is driven; must be >= 4
DEBOUNCE_CNT, 4, consecutive identical full-matrix snapshots required before the outputs change; 1..15
REPEAT_SCANS, 40, full scans a key must be held before the first auto-repeat, and between later repeats; used only with the optional feature

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
KEY_ROW  input  4  matrix row returns; active-high, pulled down on board
KEY_COL  output  3  column drive; one-hot, active-high
Keypad  output  10  debounced level; bit n = digit n held
KeypadHash  output  1  debounced level of '#'
KeypadStar  output  1  debounced level of '*'
key_strobe  output  1  one-cycle pulse on a new press (and on repeat, if enabled)
key_code  output  4  code of the strobed key: 0-9 digits, 10 = '*', 11 = '#'; held until the next strobe
key_multi  output  1  debounced snapshot has more than one key down

Behaviour:
- Reset (async, RST=1):
  - KEY_COL=3'b000; Keypad, KeypadHash, KeypadStar, key_strobe, key_code and key_multi all 0.
  - div_cnt, column index, snapshot, stable count and repeat count all cleared.
- Key map (row r, col c):
  - r0: 1, 2, 3; r1: 4, 5, 6; r2: 7, 8, 9; r3: '*', 0, '#'.
  - Snapshot bit index = r*3+c.
- Row synchroniser: KEY_ROW passes through 2 flops before use.
- Scan FSM, states COL0 -> COL1 -> COL2 -> COL0:
  - First cycle after reset release: enter COL0 with KEY_COL=3'b001.
  - Each state lasts exactly SCAN_DIV cycles; div_cnt counts 0..SCAN_DIV-1.
  - On div_cnt==SCAN_DIV-1, the synchronised rows are written into that column's 4 snapshot bits, then the FSM advances. KEY_COL changes on the same edge.
  - A full scan is 3*SCAN_DIV cycles.
- Debounce, on the cycle after the COL2 sample (snapshot complete):
  - If snapshot == prev_snapshot: stable_cnt increments, saturating at DEBOUNCE_CNT.
  - Otherwise: stable_cnt=1 and prev_snapshot=snapshot.
  - When stable_cnt reaches DEBOUNCE_CNT, the committed state takes the snapshot value on the next cycle.
  - Keypad, KeypadHash, KeypadStar and key_multi are decoded combinationally from the committed state; they update only on a commit.
- Strobe:
  - key_strobe=1 for one cycle when the committed state goes from all-zero to non-zero.
  - key_code is loaded on the same cycle with the lowest-code key present; priority order 0, 1, ..., 9, '*', '#'.
  - Adding a second key while one is already held gives no strobe; it only sets key_multi.
  - Release (commit of all-zero) gives no strobe; key_code holds its value.
- Latency: a clean press held from just before a COL0 start is committed after DEBOUNCE_CNT full scans + 2 cycles; worst case one extra scan.
- Bounce: any snapshot mismatch restarts the count; the committed state never changes on fewer than DEBOUNCE_CNT matching scans.
- Reset mid-scan: everything returns to reset values immediately; no strobe is emitted on reset release even if a key is held. The strobe fires only after a full debounce from an all-zero committed state.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - While the committed state is non-zero and unchanged, repeat_cnt counts full scans.
  - At REPEAT_SCANS: re-pulse key_strobe with the current lowest-code key, then reset repeat_cnt to 0.
  - Any commit (change or release) clears repeat_cnt.
- Undefined:
  - No repeat logic; exactly one strobe per press; REPEAT_SCANS is ignored.

Test Plan:
(all with SCAN_DIV=4, DEBOUNCE_CNT=2, REPEAT_SCANS=3; scan = 12 cycles)
- Reset: assert RST with KEY_ROW=4'b1111 -> all outputs 0, KEY_COL=000. Release -> KEY_COL sequence 001, 010, 100, changing every 4 cycles, with no strobe and no commit while RST=1.
- Digit 5 press (KEY_ROW[1]=1 only while KEY_COL=010), held -> after 2 matching scans: Keypad=10'b0000100000, key_strobe exactly one cycle, key_code=5. On release, 2 scans later Keypad=0 with no strobe.
- '#' press (row3 while col2) -> KeypadHash=1, key_code=11, Keypad=0. '*' press (row3 while col0) -> KeypadStar=1, key_code=10.
- Bounce: key 3 toggled on alternate scans for 6 scans -> no commit and no strobe. Then held stable -> one strobe, key_code=3.
- Multi-key: hold 7, then add 0 -> one strobe (key_code=7) only; after the second commit key_multi=1 and Keypad=10'b0010000001. Simultaneous 2+9 from idle -> one strobe, key_code=2.
- KEYPAD_AUTOREPEAT_EN: hold 8 for 10 scans -> strobes at commit and 3 and 6 scans after it (3 in total), all with key_code=8. Without the macro: 1 strobe.
